// File: rtl/encoder_window_ctrl_pkg.sv
// Shared types and default timing for the encoder
// measurement sequencer and the Encoder top level.
package encoder_window_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        LATCH
    } state_t;

    localparam int DEF_WINDOW_CYCLES = 100000;
    localparam int DEF_TW            = 17;
    localparam int DEF_CW            = 8;
    localparam int DEF_CLR_CYCLES    = 2;
    localparam int DEF_SETTLE_CYCLES = 2;

endpackage

// File: rtl/encoder_window_ctrl_sync.sv
// Two-flop synchroniser with a registered previous
// value for single-cycle rising-edge detection.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_q    = r_sync;
    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/encoder_window_ctrl.sv
// Gate-window sequencer: clears the Encoder, gates the
// synchronised phase for a fixed window, latches Count.
module encoder_window_ctrl
    import encoder_window_ctrl_pkg::*;
#(
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int TW            = DEF_TW,
    parameter int CW            = DEF_CW,
    parameter int CLR_CYCLES    = DEF_CLR_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          CONT,
    input  logic          A_IN,
    output logic          ENC_CLR,
    output logic          ENC_A,
    input  logic [CW-1:0] ENC_COUNT,
    output logic [CW-1:0] RESULT,
    output logic          RESULT_VALID,
    output logic          OVERFLOW,
    output logic          BUSY
);

    localparam logic [TW-1:0] LP_CLR_LAST =
        TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] LP_WIN_LAST =
        TW'(WINDOW_CYCLES - 1);
    localparam logic [TW-1:0] LP_SET_LAST =
        TW'(SETTLE_CYCLES - 1);
    localparam logic [CW:0]   LP_SHD_MAX  = '1;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_timer;
    logic [CW:0]   r_shadow;
    logic          r_armed;
    logic [CW-1:0] r_result;
    logic          r_overflow;
    logic          w_sync;
    logic          w_rise;
    logic          w_last;
    logic          w_latch_en;

    sync_edge_det u_sync (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_d     (A_IN),
        .o_q     (w_sync),
        .o_rise  (w_rise)
    );

    always_comb begin
        w_last = 1'b0;
        unique case (r_state)
            CLEAR:   w_last = (r_timer == LP_CLR_LAST);
            GATE:    w_last = (r_timer == LP_WIN_LAST);
            SETTLE:  w_last = (r_timer == LP_SET_LAST);
            default: w_last = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (START || CONT) w_next = CLEAR;
            CLEAR:   if (w_last) w_next = GATE;
            GATE:    if (w_last) w_next = SETTLE;
            SETTLE:  if (w_last) w_next = LATCH;
            LATCH:   w_next = CONT ? CLEAR : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Result registers load on the edge into LATCH so
    // RESULT is already current while RESULT_VALID is up.
    always_comb begin
        ENC_CLR      = 1'b0;
        ENC_A        = 1'b0;
        RESULT_VALID = 1'b0;
        BUSY         = 1'b1;
        w_latch_en   = 1'b0;
        unique case (r_state)
            IDLE: begin
                ENC_CLR = 1'b1;
                BUSY    = 1'b0;
            end
            CLEAR:   ENC_CLR = 1'b1;
            GATE:    ENC_A = w_sync & r_armed;
            SETTLE:  w_latch_en = w_last;
            LATCH:   RESULT_VALID = 1'b1;
            default: begin
                ENC_CLR = 1'b1;
                BUSY    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_timer <= '0;
        end else if (r_state == IDLE ||
                     r_state == LATCH || w_last) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shadow <= '0;
            r_armed  <= 1'b0;
        end else if (r_state == CLEAR) begin
            r_shadow <= '0;
            r_armed  <= 1'b0;
        end else if (r_state == GATE) begin
            if (!w_sync) begin
                r_armed <= 1'b1;
            end
            if (w_rise && r_armed &&
                r_shadow != LP_SHD_MAX) begin
                r_shadow <= r_shadow + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (w_latch_en) begin
            r_result   <= ENC_COUNT;
            r_overflow <= r_shadow[CW];
        end
    end

    assign RESULT   = r_result;
    assign OVERFLOW = r_overflow;

endmodule

// File: tb/tb_encoder_window_ctrl.sv
// Self-checking bench: behavioural window model plus
// an Encoder stand-in, directed and random stimulus.
module tb_encoder_window_ctrl;

    localparam int W     = 1000;
    localparam int CLR   = 2;
    localparam int SET   = 2;
    localparam int CW    = 8;
    localparam int TOTAL = CLR + W + SET + 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          START = 1'b0;
    logic          CONT = 1'b0;
    logic          A_IN = 1'b0;
    logic          ENC_CLR;
    logic          ENC_A;
    logic [CW-1:0] ENC_COUNT;
    logic [CW-1:0] RESULT;
    logic          RESULT_VALID;
    logic          OVERFLOW;
    logic          BUSY;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int v_cyc[$];
    int v_res[$];
    int v_ovf[$];

    encoder_window_ctrl #(
        .WINDOW_CYCLES (W),
        .TW            (17),
        .CW            (CW),
        .CLR_CYCLES    (CLR),
        .SETTLE_CYCLES (SET)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .START        (START),
        .CONT         (CONT),
        .A_IN         (A_IN),
        .ENC_CLR      (ENC_CLR),
        .ENC_A        (ENC_A),
        .ENC_COUNT    (ENC_COUNT),
        .RESULT       (RESULT),
        .RESULT_VALID (RESULT_VALID),
        .OVERFLOW     (OVERFLOW),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    // Encoder stand-in: rising edges of ENC_A, held clear
    logic r_enc_prev;
    always_ff @(posedge CLK) begin
        if (ENC_CLR) begin
            ENC_COUNT  <= '0;
            r_enc_prev <= 1'b0;
        end else begin
            r_enc_prev <= ENC_A;
            if (ENC_A && !r_enc_prev) begin
                ENC_COUNT <= ENC_COUNT + 1'b1;
            end
        end
    end

    // Reference model: offset since start decides phase
    bit       m_active = 0;
    int       m_off = 0;
    bit       m_armed = 0;
    int       m_cnt = 0;
    bit       m_sync = 0;
    bit       m_sync_prev = 0;
    bit       m_samp = 0;
    logic [7:0] m_result = 0;
    bit       m_ovf = 0;
    bit       e_busy = 0;
    bit       e_clr = 1;
    bit       e_enc_a = 0;
    bit       e_valid = 0;

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
            m_sync_prev = m_sync;
            m_sync = RST ? m_samp : 1'b0;
            m_samp = RST ? A_IN : 1'b0;
            if (!RST) begin
                m_active = 0;
                m_result = 0;
                m_ovf    = 0;
            end else if (!m_active) begin
                if (START || CONT) begin
                    m_active = 1;
                    m_off    = 0;
                end
            end else begin
                m_off++;
                if (m_off == TOTAL) begin
                    if (CONT) m_off = 0;
                    else m_active = 0;
                end
            end
            e_enc_a = 0;
            e_valid = 0;
            if (m_active && m_off == CLR) begin
                m_armed = 0;
                m_cnt   = 0;
            end
            if (m_active && m_off >= CLR &&
                m_off < CLR + W) begin
                e_enc_a = m_sync && m_armed;
                if (m_armed && m_sync && !m_sync_prev)
                    m_cnt++;
                if (!m_sync) m_armed = 1;
            end
            if (m_active && m_off == CLR + W + SET) begin
                m_result = 8'(m_cnt % 256);
                m_ovf    = (m_cnt > 255);
                e_valid  = 1;
            end
            e_busy = m_active;
            e_clr  = !m_active || (m_off < CLR);
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                chk("rst BUSY", BUSY, 0);
                chk("rst ENC_CLR", ENC_CLR, 1);
                chk("rst ENC_A", ENC_A, 0);
                chk("rst RESULT", RESULT, 0);
                chk("rst VALID", RESULT_VALID, 0);
                chk("rst OVERFLOW", OVERFLOW, 0);
            end else begin
                chk("BUSY", BUSY, e_busy);
                chk("ENC_CLR", ENC_CLR, e_clr);
                chk("ENC_A", ENC_A, e_enc_a);
                chk("RESULT_VALID", RESULT_VALID, e_valid);
                chk("RESULT", RESULT, m_result);
                chk("OVERFLOW", OVERFLOW, m_ovf);
            end
            if (RESULT_VALID === 1'b1) begin
                v_cyc.push_back(cyc);
                v_res.push_back(int'(RESULT));
                v_ovf.push_back(int'(OVERFLOW));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic lvl(input int i,
                                 input int hold_hi,
                                 input int half);
        int j;
        if (i >= W) return 1'b0;
        if (i < hold_hi) return 1'b1;
        j = i - hold_hi;
        return ((j / half) % 2) == 1;
    endfunction

    // Returns positioned to drive gate cycle 0
    task automatic launch(output int sc);
        sc = cyc;
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
    endtask

    task automatic drive(input int hold_hi,
                         input int half,
                         input int ncyc,
                         input int st_a,
                         input int st_b,
                         input int drop_at);
        for (int i = 0; i < ncyc; i++) begin
            A_IN  = lvl(i, hold_hi, half);
            START = (i == st_a) || (i == st_b);
            if (i == drop_at) CONT = 1'b0;
            tick();
        end
        START = 1'b0;
    endtask

    task automatic expect_one(input string nm,
                              input int q0,
                              input int sc,
                              input int res,
                              input int ovf);
        chk({nm, " pulses"}, v_cyc.size() - q0, 1);
        if (v_cyc.size() > q0) begin
            chk({nm, " latency"}, v_cyc[q0] - sc, TOTAL);
            chk({nm, " result"}, v_res[q0], res);
            chk({nm, " ovf"}, v_ovf[q0], ovf);
        end
    endtask

    initial begin
        int sc;
        int q0;
        #2;
        chk("init ENC_CLR", ENC_CLR, 1);
        chk("init BUSY", BUSY, 0);
        repeat (3) tick();
        RST = 1'b1;
        repeat (3) tick();

        // single shot, toggle every 50
        q0 = v_cyc.size();
        launch(sc);
        drive(0, 50, TOTAL + 10, -1, -1, -1);
        expect_one("single", q0, sc, 10, 0);

        // phase already high at gate open
        A_IN = 1'b1;
        repeat (4) tick();
        q0 = v_cyc.size();
        launch(sc);
        drive(30, 50, TOTAL + 10, -1, -1, -1);
        expect_one("high_open", q0, sc, 10, 0);

        // toggle every cycle: 499 edges wraps to 243
        q0 = v_cyc.size();
        launch(sc);
        drive(0, 1, TOTAL + 10, -1, -1, -1);
        expect_one("overflow", q0, sc, 243, 1);

        // START during GATE and SETTLE is ignored
        q0 = v_cyc.size();
        launch(sc);
        drive(0, 50, TOTAL + 10, 300, W + 1, -1);
        expect_one("start_busy", q0, sc, 10, 0);

        // continuous: three windows, CONT dropped in third
        q0 = v_cyc.size();
        CONT = 1'b1;
        launch(sc);
        drive(0, 50, TOTAL, -1, -1, -1);
        drive(0, 25, TOTAL, -1, -1, -1);
        drive(0, 100, TOTAL + 20, -1, -1, 500);
        chk("cont pulses", v_cyc.size() - q0, 3);
        if (v_cyc.size() >= q0 + 3) begin
            chk("cont lat", v_cyc[q0] - sc, TOTAL);
            chk("cont r0", v_res[q0], 10);
            chk("cont r1", v_res[q0 + 1], 20);
            chk("cont r2", v_res[q0 + 2], 5);
            chk("cont gap0",
                v_cyc[q0 + 1] - v_cyc[q0], TOTAL);
            chk("cont gap1",
                v_cyc[q0 + 2] - v_cyc[q0 + 1], TOTAL);
        end
        chk("cont idle", BUSY, 0);

        // reset mid-gate
        q0 = v_cyc.size();
        launch(sc);
        drive(0, 50, 500, -1, -1, -1);
        RST = 1'b0;
        #1;
        chk("midrst ENC_CLR", ENC_CLR, 1);
        chk("midrst BUSY", BUSY, 0);
        chk("midrst RESULT", RESULT, 0);
        chk("midrst ENC_A", ENC_A, 0);
        A_IN = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        repeat (5) tick();
        chk("midrst no valid", v_cyc.size() - q0, 0);
        q0 = v_cyc.size();
        launch(sc);
        drive(0, 50, TOTAL + 10, -1, -1, -1);
        expect_one("after_rst", q0, sc, 10, 0);

        // random phase noise and stray START pulses
        for (int w = 0; w < 4; w++) begin
            int p;
            p = $urandom_range(0, 12);
            q0 = v_cyc.size();
            launch(sc);
            for (int i = 0; i < TOTAL + 12; i++) begin
                if ($urandom_range(0, p) == 0)
                    A_IN = ~A_IN;
                START = ($urandom_range(0, 300) == 0);
                tick();
            end
            START = 1'b0;
            A_IN  = 1'b0;
            chk("rand pulse", v_cyc.size() > q0, 1);
            repeat (TOTAL + 5) tick();
        end

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_window_ctrl.md
Name: encoder_window_ctrl

Overview:
- Measurement sequencer for the single-channel pulse Encoder (CLK, RST, A -> Count[7:0]).
- Synchronises the raw encoder phase and opens a fixed gate window. The Encoder's count is cleared before each window and held stable after it.
- Latches Count as a per-window pulse rate, with valid and overflow flags.
- Sits between the pad-level encoder signal and the Encoder instance; single-shot or continuous mode.

Parameters:
- WINDOW_CYCLES, 100000, gate length in CLK cycles (1 ms at 100 MHz)
- TW, 17, window timer width; must satisfy 2^TW > WINDOW_CYCLES
- CW, 8, Encoder count width
- CLR_CYCLES, 2, cycles ENC_CLR is held high before each window
- SETTLE_CYCLES, 2, post-gate cycles before Count is sampled

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- START  in  1  level, sampled in IDLE; begins a measurement
- CONT  in  1  continuous mode; re-arm after every LATCH while high
- A_IN  in  1  raw asynchronous encoder phase
- ENC_CLR  out  1  drives Encoder RST (active-high clear)
- ENC_A  out  1  gated, synchronised phase to Encoder A
- ENC_COUNT  in  CW  Encoder Count
- RESULT  out  CW  rising edges counted in last window
- RESULT_VALID  out  1  one-cycle pulse when RESULT updates
- OVERFLOW  out  1  last window exceeded 2^CW-1 edges; updated with RESULT
- BUSY  out  1  high in any state other than IDLE

Behaviour:
- Encoder contract: counts rising edges of ENC_A, wraps at 2^CW, held at 0 while ENC_CLR=1.
- A_IN passes through a 2-flop synchroniser (a_sync). A rising edge is a_sync=1 with its previous value 0.
- Reset (RST=0, any time, mid-window included) takes effect immediately:
  - state=IDLE, timer=0, shadow counter=0
  - ENC_CLR=1, ENC_A=0
  - RESULT=0, RESULT_VALID=0, OVERFLOW=0, BUSY=0
  - synchroniser flops=0
- IDLE:
  - ENC_CLR=1, ENC_A=0.
  - START=1 (or CONT=1) -> CLEAR on the next edge.
- CLEAR:
  - ENC_CLR=1 for exactly CLR_CYCLES cycles, then -> GATE.
  - Timer, shadow counter and the armed flag are zeroed here.
- GATE: lasts exactly WINDOW_CYCLES cycles.
  - ENC_CLR=0, ENC_A = a_sync AND armed.
  - armed sets on the first cycle a_sync=0 in GATE. If the phase is already high at gate open, no spurious edge is counted.
  - Shadow counter (CW+1 bits, saturating) increments on each a_sync rising edge while armed.
  - Timer reaches WINDOW_CYCLES-1 -> SETTLE.
- SETTLE:
  - ENC_A forced 0 (a falling edge only, never counted), ENC_CLR=0.
  - Lasts SETTLE_CYCLES cycles, then -> LATCH.
- LATCH: one cycle.
  - RESULT <= ENC_COUNT; OVERFLOW <= shadow count > 2^CW-1; RESULT_VALID=1 for this cycle only.
  - Next state: CLEAR if CONT=1, else IDLE.
- Latency: START sampled high at edge k gives RESULT_VALID high in cycle k+1+CLR_CYCLES+WINDOW_CYCLES+SETTLE_CYCLES; with defaults, k+100005.
  - Continuous mode: one result every CLR_CYCLES+WINDOW_CYCLES+SETTLE_CYCLES+1 cycles.
- START while BUSY is ignored; no queueing.
- CONT dropped mid-window: the current window completes and is latched, then -> IDLE.
- RESULT and OVERFLOW hold between LATCH events.
- RESULT wraps with the Encoder count. OVERFLOW is the only indication of wrap.

Decomposition:
- Shared package holds:
  - state enum: IDLE, CLEAR, GATE, SETTLE, LATCH
  - defaults for WINDOW_CYCLES, CLR_CYCLES, SETTLE_CYCLES and CW, for reuse by the Encoder top level
- One sub-module: sync_edge_det (2-flop synchroniser plus rising-edge pulse, async active-low reset). It is reused for the START pad later.
- FSM, timer, shadow counter and result registers stay in encoder_window_ctrl.

Test Plan:
1. Single shot: WINDOW_CYCLES=1000, A_IN low at START, toggling every 50 cycles from gate open -> exactly one RESULT_VALID pulse; RESULT=10, OVERFLOW=0; BUSY low on the cycle after LATCH.
2. Gate opens with A_IN held high, 30 cycles then toggling every 50 cycles -> the initial high is not counted; RESULT matches the shadow count; ENC_A stays 0 until a_sync has been low once.
3. Overflow: WINDOW_CYCLES=1100, A_IN toggling every 2 cycles -> OVERFLOW=1, RESULT=275 mod 256=19.
4. Continuous: CONT=1, three windows with toggle periods 50/25/100 cycles -> RESULT 10/20/5. RESULT_VALID pulses exactly 1005 cycles apart. CONT dropped in window 3 still yields its result, then IDLE.
5. Reset mid-GATE: RST=0 for 3 cycles at window cycle 500 -> all outputs at reset values within the same cycle, ENC_CLR=1. No RESULT_VALID; a new START runs a clean full window.
6. START pulsed during GATE and SETTLE -> ignored; timing and RESULT identical to scenario 1.
